gray_seq_checker: RTL
=====================

Name: gray_seq_checker

Overview:
- Downstream consumer of the Gray counter output.
- Samples the Gray code on a one-cycle strobe, registers it and converts it to binary.
- Checks that every new sample is a legal single-step Gray transition, counts wrap-arounds and errors, and tracks lock state so the board reports counter health.
- All logic runs on the fast system clock; the slow counter rate arrives as the `gray_valid` strobe, never as a clock.

Parameters:
- W, 3, Gray code width in bits (valid range 2..8).
- ALLOW_REVERSE, 0, 1 = binary −1 steps are legal; 0 = down steps count as errors.
- RELOCK_LEN, 4, consecutive good steps needed to leave RESYNC for TRACK.
- CNT_W, 8, width of `err_count` and `wrap_count`.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- gray_in  in  W  Gray code from the counter; sampled only when `gray_valid`=1.
- gray_valid  in  1  one-cycle sample strobe.
- bin_out  out  W  binary equivalent of the last accepted sample.
- bin_valid  out  1  one-cycle pulse, 1 cycle after `gray_valid`.
- step_err  out  1  one-cycle pulse, coincident with `bin_valid`, when the sample is an illegal step.
- err_sticky  out  1  set on the first error, cleared only by `rst`.
- err_count  out  CNT_W  saturating count of errors.
- wrap_count  out  CNT_W  wrapping count of up-wraps (max→0) and down-wraps (0→max).
- locked  out  1  high while in TRACK.

Behaviour:
- Reset (sync, `rst`=1 at a clk edge) clears every output and all internal registers to 0. State goes to SYNC. `rst` overrides `gray_valid` in the same cycle.
- Conversion: b[W-1]=g[W-1]; b[i]=b[i+1]^g[i] for i=W-2..0.
  - Combinational from the `gray_in` sample; `bin_out` is registered.
  - Latency: `gray_valid` at edge N → `bin_out`/`bin_valid`/`step_err` updated at edge N+1.
- Step classification of each sample against the previous accepted Gray value `prev_g`:
  - HOLD: popcount(gray_in^prev_g)=0. No step, not an error; `bin_valid` still pulses.
  - UP: popcount=1 and bin_new = bin_prev+1 mod 2^W.
  - DOWN: popcount=1 and bin_new = bin_prev−1 mod 2^W. Legal only if ALLOW_REVERSE=1, else ERR.
  - ERR: popcount≥2, or DOWN with ALLOW_REVERSE=0.
- `prev_g` updates on every sample, including erroneous ones. After an error, checking continues from the new value.
- State machine, advancing only on `gray_valid` cycles:
  - SYNC: first sample is accepted as reference with no classification and no error → RESYNC, good_run=0.
  - RESYNC: UP/legal DOWN → good_run+1; at good_run=RELOCK_LEN−1 → TRACK. HOLD leaves good_run unchanged. ERR → good_run=0 and is reported (`step_err`, `err_count`, `err_sticky`).
  - TRACK: UP/legal DOWN/HOLD → stay. ERR → RESYNC, good_run=0.
- `locked`=1 exactly while state=TRACK; registered, changes at the same edge as `bin_valid`.
- Wrap detect: UP with bin_prev=2^W−1, or legal DOWN with bin_prev=0, increments `wrap_count`. It wraps modulo 2^CNT_W and counts in every state except SYNC.
- `err_count` saturates at 2^CNT_W−1 and never wraps. `err_sticky` stays 1 until `rst`.
- Back-to-back strobes (`gray_valid` high on consecutive cycles) must be handled at full rate: one sample per cycle, no drops.
- Reset mid-run: the next sample after reset is treated as a SYNC reference. No error is reported even if it is far from the pre-reset value.

Test Plan:
- W=3, ALLOW_REVERSE=0. Reset, then strobe Gray 000,001,011,010,110,111,101,100,000.
  - `bin_out` sequence 0,1,2,3,4,5,6,7,0.
  - `locked` rises on the 5th sample.
  - `wrap_count`=1, `err_count`=0, `step_err` never pulses.
- Locked at Gray 011, then strobe 110 (2-bit change).
  - `step_err` pulses 1 cycle after the strobe; `err_count`=1, `err_sticky`=1, `locked`→0.
  - The next 4 legal UP steps from 110 (111,101,100,000) restore `locked`=1.
- Locked at Gray 011 (bin 2), strobe 001 (bin 1).
  - ALLOW_REVERSE=0: `step_err`=1.
  - Rerun with ALLOW_REVERSE=1: no error. Continue 000 then 100: `wrap_count` increments once on 0→7.
- Strobe the same Gray value 5 times while locked.
  - 5 `bin_valid` pulses, no errors, `locked` stays 1, `wrap_count` unchanged.
- CNT_W=2. Inject 5 multi-bit errors → `err_count` holds at 3, `step_err` pulses 5 times.
- Assert `rst` in the same cycle as `gray_valid` with an illegal value.
  - All outputs 0 the next cycle, no `step_err` pulse.
  - The next sample (e.g. Gray 101) is accepted as the reference with no error.

Source files
------------

// File: rtl/gray_seq_checker.sv
// Gray code sample checker: converts strobed Gray samples to binary,
// validates single-step transitions and tracks lock, error and wrap state.
module gray_seq_checker #(
    parameter int W             = 3,
    parameter int ALLOW_REVERSE = 0,
    parameter int RELOCK_LEN    = 4,
    parameter int CNT_W         = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [W-1:0]     gray_in,
    input  logic             gray_valid,
    output logic [W-1:0]     bin_out,
    output logic             bin_valid,
    output logic             step_err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] err_count,
    output logic [CNT_W-1:0] wrap_count,
    output logic             locked
);

    localparam int GW = (RELOCK_LEN > 1) ? $clog2(RELOCK_LEN) : 1;
    localparam logic [GW-1:0] RUN_LIM = GW'(RELOCK_LEN - 1);
    localparam logic [W-1:0] BIN_MAX = '1;
    localparam bit REV_OK = (ALLOW_REVERSE != 0);

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        RESYNC = 2'd1,
        TRACK  = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [W-1:0]  prev_g;
    logic [W-1:0]  bin_new;
    logic [W-1:0]  bin_prev;
    logic [GW-1:0] good_run;
    logic [GW-1:0] run_nxt;
    logic          is_hold;
    logic          is_up;
    logic          is_down;
    logic          is_good;
    logic          is_err;
    logic          is_wrap;
    logic          err_evt;
    logic          wrap_evt;

    function automatic logic [W-1:0] gray2bin(input logic [W-1:0] g);
        logic [W-1:0] b;
        b[W-1] = g[W-1];
        for (int i = W - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    // A single-bit Gray flip is only legal if it moves the count by one.
    always_comb begin
        bin_new  = gray2bin(gray_in);
        bin_prev = gray2bin(prev_g);
        is_hold  = (gray_in == prev_g);
        is_up    = (bin_new == bin_prev + W'(1));
        is_down  = (bin_new == bin_prev - W'(1));
        is_good  = is_up || (is_down && REV_OK);
        is_err   = !is_hold && !is_good;
        is_wrap  = (is_up && bin_prev == BIN_MAX)
                || (is_down && REV_OK && bin_prev == '0);
    end

    always_comb begin
        state_nxt = state;
        if (gray_valid) begin
            unique case (state)
                SYNC:   state_nxt = RESYNC;
                RESYNC: begin
                    if (is_good && good_run == RUN_LIM) begin
                        state_nxt = TRACK;
                    end
                end
                TRACK:  begin
                    if (is_err) begin
                        state_nxt = RESYNC;
                    end
                end
                default: state_nxt = SYNC;
            endcase
        end
    end

    always_comb begin
        err_evt  = 1'b0;
        wrap_evt = 1'b0;
        run_nxt  = good_run;
        if (gray_valid) begin
            unique case (state)
                SYNC:   run_nxt = '0;
                RESYNC: begin
                    err_evt  = is_err;
                    wrap_evt = is_wrap;
                    if (is_err) begin
                        run_nxt = '0;
                    end else if (is_good) begin
                        run_nxt = (good_run == RUN_LIM) ? '0
                                : good_run + GW'(1);
                    end
                end
                TRACK:  begin
                    err_evt  = is_err;
                    wrap_evt = is_wrap;
                    if (is_err) begin
                        run_nxt = '0;
                    end
                end
                default: run_nxt = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SYNC;
            good_run   <= '0;
            prev_g     <= '0;
            bin_out    <= '0;
            bin_valid  <= 1'b0;
            step_err   <= 1'b0;
            err_sticky <= 1'b0;
            err_count  <= '0;
            wrap_count <= '0;
            locked     <= 1'b0;
        end else begin
            state     <= state_nxt;
            good_run  <= run_nxt;
            bin_valid <= gray_valid;
            step_err  <= err_evt;
            locked    <= (state_nxt == TRACK);
            if (gray_valid) begin
                prev_g  <= gray_in;
                bin_out <= bin_new;
            end
            if (err_evt) begin
                err_sticky <= 1'b1;
            end
            if (err_evt && err_count != '1) begin
                err_count <= err_count + CNT_W'(1);
            end
            if (wrap_evt) begin
                wrap_count <= wrap_count + CNT_W'(1);
            end
        end
    end

endmodule
